encoder4_2_pipe: RTL and testbench

ENCODER4_2_PIPE -- requirements
Module: encoder4_2_pipe

---
 rtl/encoder4_2_pipe.sv | 164 ++++++++++++++++
 tb/tb_encoder4_2_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder4_2_pipe.sv
// encoder4_2_pipe
//
// Priority 4-to-2 encoder feeding a 2-entry in-order result FIFO with
// valid/ready handshakes on both sides.
// - The highest set request line wins: i3 -> 11, i2 -> 10, i1 -> 01, else 00.
// - err marks words that are not one-hot, including all-zero and multi-hot words.
// - err_cnt is a saturating count of accepted non-one-hot words.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   producer presents a word on i0..i3
//   in_ready   out  block can accept a word this cycle (registered, gated by rst)
//   i0..i3     in   request lines, i0 is index 0
//   out_valid  out  e0/e1/err hold a valid result (head of the FIFO)
//   out_ready  in   consumer takes the head result this cycle
//   e0, e1     out  encoded index of the head entry, e0 is the LSB
//   err        out  head entry came from a non-one-hot word
//   err_cnt    out  saturating count of accepted non-one-hot words

module encoder4_2_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       e0,
  output logic       e1,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } state_e;

  // One FIFO entry: encoded index plus its error flag.
  typedef struct packed {
    logic [1:0] code;
    logic       err;
  } entry_t;

  state_e     state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       in_ready_q, in_ready_d;

  logic [3:0] word;
  logic [1:0] enc_code;
  logic       one_hot;
  entry_t     enc_entry;
  logic       push;
  logic       pop;

  // Encoder
  assign word = {i3, i2, i1, i0};

  always_comb begin
    enc_code = 2'd0;
    if (i3) begin
      enc_code = 2'd3;
    end else if (i2) begin
      enc_code = 2'd2;
    end else if (i1) begin
      enc_code = 2'd1;
    end
  end

  // Non-zero with a single bit set: clearing the lowest set bit leaves zero.
  assign one_hot   = (word != 4'd0) && ((word & (word - 4'd1)) == 4'd0);
  assign enc_entry = '{code: enc_code, err: ~one_hot};

  // Handshakes
  // in_ready comes from a register, so it has no path from out_ready. It is
  // gated by rst so that it reads low throughout reset.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state logic
  // head_q always holds the oldest entry; tail_q is valid only in StFull.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;

    case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          head_d  = enc_entry;
        end
      end
      StOne: begin
        if (push && pop) begin
          // Old head leaves this cycle and the new word takes its place with no bubble.
          head_d = enc_entry;
        end else if (push) begin
          state_d = StFull;
          tail_d  = enc_entry;
        end else if (pop) begin
          state_d = StEmpty;
          head_d  = '0;
        end
      end
      StFull: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_d = StOne;
          head_d  = tail_q;
          tail_d  = '0;
        end
      end
      default: begin
        state_d = StEmpty;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_entry.err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign in_ready_d = (state_d != StFull);

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      tail_q     <= '0;
      err_cnt_q  <= '0;
      // Held high so the first cycle after release can accept a word.
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      err_cnt_q  <= err_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Outputs
  assign e0      = head_q.code[0];
  assign e1      = head_q.code[1];
  assign err     = head_q.err;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_encoder4_2_pipe.sv
module tb_encoder4_2_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       i0, i1, i2, i3;
  logic       out_valid;
  logic       out_ready;
  logic       e0, e1, err;
  logic [7:0] err_cnt;

  int n_checks;
  int n_fail;

  encoder4_2_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .e0        (e0),
    .e1        (e1),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word[k] drives ik
  typedef struct {
    logic [3:0] word;
    logic [1:0] code;
    logic       err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [3:0] w);
    i0 = w[0];
    i1 = w[1];
    i2 = w[2];
    i3 = w[3];
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // i0..i3 = 1000, 0100, 0010, 0001, 0000, 1111, 0110
    vecs[0] = '{word: 4'b0001, code: 2'd0, err: 1'b0};
    vecs[1] = '{word: 4'b0010, code: 2'd1, err: 1'b0};
    vecs[2] = '{word: 4'b0100, code: 2'd2, err: 1'b0};
    vecs[3] = '{word: 4'b1000, code: 2'd3, err: 1'b0};
    vecs[4] = '{word: 4'b0000, code: 2'd0, err: 1'b1};
    vecs[5] = '{word: 4'b1111, code: 2'd3, err: 1'b1};
    vecs[6] = '{word: 4'b0110, code: 2'd2, err: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_word(4'b0000);
    tick();
    tick();

    // Reset state while rst is still high
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst code", {30'd0, e1, e0}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("release in_ready", {31'd0, in_ready}, 32'd1);

    // Table sweep, streamed one word per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      set_word(vecs[k].word);
      tick();
      check($sformatf("vec%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d code", k), {30'd0, e1, e0}, {30'd0, vecs[k].code});
      check($sformatf("vec%0d err", k), {31'd0, err}, {31'd0, vecs[k].err});
      check($sformatf("vec%0d in_ready", k), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("drain out_valid", {31'd0, out_valid}, 32'd0);
    check("sweep err_cnt", {24'd0, err_cnt}, 32'd3);

    // Backpressure: fill, hold, ignore blocked input, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_word(4'b0100);
    tick();
    check("bp first code", {30'd0, e1, e0}, 32'd2);
    check("bp one in_ready", {31'd0, in_ready}, 32'd1);
    set_word(4'b1000);
    tick();
    check("bp full in_ready", {31'd0, in_ready}, 32'd0);
    check("bp full code", {30'd0, e1, e0}, 32'd2);
    set_word(4'b0000);
    tick();
    check("bp hold code", {30'd0, e1, e0}, 32'd2);
    check("bp hold err", {31'd0, err}, 32'd0);
    check("bp hold out_valid", {31'd0, out_valid}, 32'd1);
    check("bp blocked err_cnt", {24'd0, err_cnt}, 32'd3);
    out_ready = 1'b1;
    tick();
    check("bp second code", {30'd0, e1, e0}, 32'd3);
    check("bp second out_valid", {31'd0, out_valid}, 32'd1);
    check("bp in_ready after pop", {31'd0, in_ready}, 32'd1);
    check("bp pop-cycle err_cnt", {24'd0, err_cnt}, 32'd3);
    in_valid = 1'b0;
    tick();
    check("bp empty out_valid", {31'd0, out_valid}, 32'd0);

    // Saturation: 260 all-zero words
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    set_word(4'b0000);
    repeat (254) tick();
    check("sat 254", {24'd0, err_cnt}, 32'd254);
    tick();
    check("sat 255", {24'd0, err_cnt}, 32'd255);
    repeat (5) tick();
    check("sat hold", {24'd0, err_cnt}, 32'd255);
    in_valid = 1'b0;
    tick();

    // Reset while FULL with err_cnt = 5
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    set_word(4'b0000);
    repeat (5) tick();
    in_valid = 1'b0;
    tick();
    check("pre-rst err_cnt", {24'd0, err_cnt}, 32'd5);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_word(4'b0001);
    tick();
    set_word(4'b0010);
    tick();
    check("pre-rst in_ready", {31'd0, in_ready}, 32'd0);
    check("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst in_ready comb", {31'd0, in_ready}, 32'd0);
    tick();
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-rst err_cnt", {24'd0, err_cnt}, 32'd0);
    check("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
    check("mid-rst code", {30'd0, e1, e0}, 32'd0);
    check("mid-rst err", {31'd0, err}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("post-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("post-rst err_cnt", {24'd0, err_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
